// File: rtl/game_over_pkg.sv
// Shared types and screen geometry for the game-over sequencing block.
package game_over_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned BITMAP_W = 32;
  localparam int unsigned BITMAP_H = 32;

  // Default resting position centres the bitmap on screen.
  localparam int unsigned DEF_TARGET_X = (SCREEN_W - BITMAP_W) / 2;
  localparam int unsigned DEF_TARGET_Y = (SCREEN_H - BITMAP_H) / 2;

  typedef enum logic [2:0] {
    PLAY    = 3'd0,
    FREEZE  = 3'd1,
    SLIDE   = 3'd2,
    BLINK   = 3'd3,
    SHOW    = 3'd4,
    RESTART = 3'd5
  } state_t;

endpackage

// File: rtl/frame_tick_counter.sv
// Frame counter: counts tick pulses up to limit and holds there until cleared.
module frame_tick_counter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick,
  input  logic       clear,
  input  logic [7:0] limit,
  output logic       done,
  output logic       last
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !done) begin
      count <= count + 8'd1;
    end
  end

  // last flags the tick that brings the count up to limit, so callers can act on that same frame.
  always_comb begin
    done = (count == limit);
    last = tick && !done && ((count + 8'd1) == limit);
  end

endmodule

// File: rtl/game_over_controller.sv
// End-of-game sequencer: freeze, slide-in, blink and hold the GAME OVER bitmap, then restart.
module game_over_controller
  import game_over_pkg::*;
#(
  parameter int unsigned FREEZE_FRAMES   = 30,
  parameter int unsigned START_Y         = 0,
  parameter int unsigned TARGET_X        = DEF_TARGET_X,
  parameter int unsigned TARGET_Y        = DEF_TARGET_Y,
  parameter int unsigned SLIDE_STEP      = 8,
  parameter int unsigned BLINK_FRAMES    = 15,
  parameter int unsigned BLINK_TOGGLES   = 6,
  parameter int unsigned MIN_SHOW_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        birdsExhausted,
  input  logic        allSettled,
  input  logic [3:0]  pigsRemaining,
  input  logic        restartKey,
  output logic        gameOver,
  output logic        freezeGame,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        restartPulse,
  output logic [2:0]  stateOut
);

  localparam logic [10:0] TX = 11'(TARGET_X);
  localparam logic [10:0] SY = 11'(START_Y);
  localparam logic [10:0] TY = 11'(TARGET_Y);
  localparam logic [11:0] STEP = 12'(SLIDE_STEP);
  localparam logic [7:0]  FF = 8'(FREEZE_FRAMES);
  localparam logic [7:0]  BF = 8'(BLINK_FRAMES);
  localparam logic [7:0]  MS = 8'(MIN_SHOW_FRAMES);
  localparam logic [3:0]  BT = 4'(BLINK_TOGGLES);

  state_t      state;
  logic [3:0]  toggles;
  logic        key_prev;
  logic        key_edge;
  logic [11:0] sum;
  logic [10:0] y_next;
  logic        cnt_clear;
  logic [7:0]  cnt_limit;
  logic        cnt_done;
  logic        cnt_last;

  frame_tick_counter u_frames (
    .clk    (clk),
    .resetN (resetN),
    .tick   (startOfFrame),
    .clear  (cnt_clear),
    .limit  (cnt_limit),
    .done   (cnt_done),
    .last   (cnt_last)
  );

  always_comb begin
    key_edge = restartKey && !key_prev;
    sum      = {1'b0, topLeftY} + STEP;
    y_next   = (sum >= {1'b0, TY}) ? TY : sum[10:0];
    cnt_limit = '0;
    case (state)
      FREEZE:  cnt_limit = FF;
      BLINK:   cnt_limit = BF;
      SHOW:    cnt_limit = MS;
      default: cnt_limit = '0;
    endcase
    // The shared counter is restarted whenever a timed phase completes, and held at zero outside timed phases.
    cnt_clear = (state == PLAY) || (state == SLIDE) || (state == RESTART) ||
                (((state == FREEZE) || (state == BLINK)) && cnt_last);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= PLAY;
      gameOver     <= 1'b0;
      freezeGame   <= 1'b0;
      topLeftX     <= TX;
      topLeftY     <= SY;
      restartPulse <= 1'b0;
      toggles      <= '0;
      key_prev     <= 1'b0;
    end else begin
      key_prev     <= restartKey;
      topLeftX     <= TX;
      restartPulse <= 1'b0;
      unique case (state)
        PLAY: begin
          gameOver   <= 1'b0;
          freezeGame <= 1'b0;
          if (startOfFrame && birdsExhausted && allSettled && (pigsRemaining != 4'd0)) begin
            state      <= FREEZE;
            freezeGame <= 1'b1;
          end
        end
        FREEZE: begin
          if (cnt_last) begin
            state    <= SLIDE;
            gameOver <= 1'b1;
            topLeftY <= SY;
          end
        end
        SLIDE: begin
          if (startOfFrame) begin
            topLeftY <= y_next;
            if (y_next == TY) begin
              state   <= BLINK;
              toggles <= '0;
            end
          end
        end
        BLINK: begin
          if (cnt_last) begin
            toggles <= toggles + 4'd1;
            if ((toggles + 4'd1) == BT) begin
              state    <= SHOW;
              gameOver <= 1'b1;
            end else begin
              gameOver <= !gameOver;
            end
          end
        end
        SHOW: begin
          if (key_edge && cnt_done) begin
            state        <= RESTART;
            restartPulse <= 1'b1;
            gameOver     <= 1'b0;
          end
        end
        RESTART: begin
          state      <= PLAY;
          freezeGame <= 1'b0;
          topLeftY   <= SY;
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign stateOut = state;

endmodule

// File: tb/tb_game_over_controller.sv
// Directed bench for game_over_controller: cycle table plus hand-written reset/recovery sequence.
module tb_game_over_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        birdsExhausted = 1'b0;
  logic        allSettled = 1'b0;
  logic [3:0]  pigsRemaining = 4'd0;
  logic        restartKey = 1'b0;
  logic        gameOver;
  logic        freezeGame;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        restartPulse;
  logic [2:0]  stateOut;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_over_controller #(
    .FREEZE_FRAMES   (3),
    .START_Y         (0),
    .TARGET_X        (304),
    .TARGET_Y        (20),
    .SLIDE_STEP      (8),
    .BLINK_FRAMES    (2),
    .BLINK_TOGGLES   (4),
    .MIN_SHOW_FRAMES (5)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .birdsExhausted (birdsExhausted),
    .allSettled     (allSettled),
    .pigsRemaining  (pigsRemaining),
    .restartKey     (restartKey),
    .gameOver       (gameOver),
    .freezeGame     (freezeGame),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .restartPulse   (restartPulse),
    .stateOut       (stateOut)
  );

  typedef struct {
    logic       sof;
    logic       birds;
    logic       settled;
    logic [3:0] pigs;
    logic       key;
    logic [2:0] st;
    logic       go;
    logic       fz;
    logic [10:0] y;
    logic       pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sof, input logic b, input logic s, input logic [3:0] p,
                              input logic k, input logic [2:0] st, input logic go, input logic fz,
                              input logic [10:0] y, input logic pl);
    vec_t v;
    v.sof = sof; v.birds = b; v.settled = s; v.pigs = p; v.key = k;
    v.st = st; v.go = go; v.fz = fz; v.y = y; v.pulse = pl;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int go, input int fz,
                           input int y, input int pl);
    check({tag, "_state"}, int'(stateOut), st);
    check({tag, "_gameOver"}, int'(gameOver), go);
    check({tag, "_freeze"}, int'(freezeGame), fz);
    check({tag, "_topLeftY"}, int'(topLeftY), y);
    check({tag, "_restartPulse"}, int'(restartPulse), pl);
    check({tag, "_topLeftX"}, int'(topLeftX), 304);
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    //                sof b  s  pigs k   st go fz y   pl
    vecs.push_back(mk(0, 1, 1, 4'd2, 0, 0, 0, 0, 0, 0)); // condition true but no frame pulse
    vecs.push_back(mk(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0)); // all pigs dead: a win
    vecs.push_back(mk(1, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'd2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'd2, 0, 1, 0, 1, 0, 0)); // enter FREEZE
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 1, 0, 1, 0, 0)); // freeze frame 1
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 1, 0, 1, 0, 0)); // freeze frame 2
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 2, 1, 1, 0, 0)); // frame 3 -> SLIDE
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 2, 1, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 2, 1, 1, 8, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 2, 1, 1, 16, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 1, 1, 20, 0)); // clamped -> BLINK
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 1, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 0, 1, 20, 0)); // toggle 1
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 3, 0, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 0, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 1, 1, 20, 0)); // toggle 2
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 1, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 0, 1, 20, 0)); // toggle 3
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 3, 0, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 4, 1, 1, 20, 0)); // toggle 4 -> SHOW
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 4, 1, 1, 20, 0)); // show frame 1
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 4, 1, 1, 20, 0)); // early edge, ignored
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 4, 1, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 4, 1, 1, 20, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 4, 1, 1, 20, 0)); // saturates at 5
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 4, 1, 1, 20, 0)); // held key, no edge
    vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4, 1, 1, 20, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4, 1, 1, 20, 0)); // release
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 5, 0, 1, 20, 1)); // edge + frame together -> RESTART
    vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 0, 0, 0)); // back to PLAY
    vecs.push_back(mk(0, 1, 1, 4'd2, 0, 0, 0, 0, 0, 0)); // waits for a frame pulse
    vecs.push_back(mk(1, 1, 1, 4'd2, 0, 1, 0, 1, 0, 0)); // re-enters FREEZE

    #12 resetN = 1'b1;
    #1 check_all("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      startOfFrame   = vecs[i].sof;
      birdsExhausted = vecs[i].birds;
      allSettled     = vecs[i].settled;
      pigsRemaining  = vecs[i].pigs;
      restartKey     = vecs[i].key;
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i), int'(vecs[i].st), int'(vecs[i].go), int'(vecs[i].fz),
                int'(vecs[i].y), int'(vecs[i].pulse));
    end

    // Walk from FREEZE into BLINK, then hit reset mid-cycle.
    startOfFrame = 1'b0; birdsExhausted = 1'b0; allSettled = 1'b0; pigsRemaining = 4'd0;
    restartKey = 1'b0;
    repeat (3) frame();
    check_all("seq_slide", 2, 1, 1, 0, 0);
    repeat (3) frame();
    check_all("seq_blink", 3, 1, 1, 20, 0);
    frame();
    check_all("seq_blink2", 3, 1, 1, 20, 0);
    #2 resetN = 1'b0;
    #1 check_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    check_all("reset_hold", 0, 0, 0, 0, 0);
    resetN = 1'b1;
    @(posedge clk); #1;
    birdsExhausted = 1'b1; allSettled = 1'b1; pigsRemaining = 4'd7;
    @(posedge clk); #1;
    check_all("post_reset_noframe", 0, 0, 0, 0, 0);
    frame();
    check_all("post_reset_freeze", 1, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/game_over_controller.md
Name: game_over_controller

Overview:
- Sequences the end-of-game display: detects the lose condition, freezes gameplay, then slides, blinks and holds the 32x32 "GAME OVER" bitmap.
- Waits for a restart key, then issues a restart pulse.
- Sits between the game-logic objects and the game-over bitmap drawer. Drives that drawer's GAMEOVER enable and the top-left corner of its bounding rectangle.
- All animation timing is in video frames, counted on startOfFrame pulses.

Parameters:
FREEZE_FRAMES, 30, frames gameplay stays frozen before the bitmap appears (1..255)
START_Y, 0, initial top-left Y of the bitmap rectangle during slide-in
TARGET_X, 304, fixed top-left X of the rectangle (centred for 640-wide screen)
TARGET_Y, 224, final top-left Y of the rectangle
SLIDE_STEP, 8, pixels added to Y per frame during slide-in (1..64)
BLINK_FRAMES, 15, frames per blink half-period (1..255)
BLINK_TOGGLES, 6, number of visibility toggles in BLINK; must be even (2..14)
MIN_SHOW_FRAMES, 60, frames in SHOW before a restart edge is accepted (0..255)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per video frame
birdsExhausted  in  1  no birds left to launch (level)
allSettled  in  1  all physics objects stationary (level)
pigsRemaining  in  4  count of live pigs
restartKey  in  1  raw restart key level, already synchronised
gameOver  out  1  enable to the bitmap drawer (its GAMEOVER input)
freezeGame  out  1  halts movement/physics blocks
topLeftX  out  11  rectangle top-left X
topLeftY  out  11  rectangle top-left Y
restartPulse  out  1  one-clk pulse to reset game logic
stateOut  out  3  current state encoding, for debug/LEDs

Behaviour:
- Reset (resetN asynchronous, active-low; clock clk). All outputs are registered.
  - Reset values: state=PLAY, gameOver=0, freezeGame=0, topLeftX=TARGET_X, topLeftY=START_Y, restartPulse=0, all counters 0.
- Reset asserted mid-sequence returns to PLAY immediately.
- States (encoding 0..5): PLAY, FREEZE, SLIDE, BLINK, SHOW, RESTART.
- PLAY -> FREEZE: on a clk where startOfFrame=1, birdsExhausted=1, allSettled=1 and pigsRemaining!=0.
  - The condition is sampled only on startOfFrame, so mid-frame glitches are ignored.
  - With pigsRemaining==0 the block stays in PLAY (a win is not game over).
- FREEZE: freezeGame=1, gameOver=0. The frame counter increments on each startOfFrame.
  - When the counter reaches FREEZE_FRAMES: clear the counter, go to SLIDE, load topLeftY=START_Y.
- SLIDE: freezeGame=1, gameOver=1.
  - On each startOfFrame, topLeftY <= min(topLeftY+SLIDE_STEP, TARGET_Y). Compute the sum in 12 bits, then clamp.
  - On the frame where the updated value equals TARGET_Y, go to BLINK with counter=0, toggles=0.
- BLINK: freezeGame=1, topLeftY=TARGET_Y.
  - Every BLINK_FRAMES startOfFrame pulses, invert gameOver and increment toggles.
  - When toggles reaches BLINK_TOGGLES, go to SHOW with gameOver=1 and counter cleared. BLINK_TOGGLES is even, so the bitmap ends visible.
- SHOW: gameOver=1, freezeGame=1.
  - The frame counter saturates at MIN_SHOW_FRAMES.
  - A rising edge of restartKey (registered previous value) is accepted only when counter==MIN_SHOW_FRAMES. Accepted edge -> RESTART.
  - Edges before that are ignored; they do not queue.
  - restartKey held high from an earlier press gives no edge and no restart.
- RESTART: lasts exactly 1 clk. restartPulse=1, gameOver=0, freezeGame=1.
  - Next clk: PLAY with restartPulse=0, freezeGame=0, topLeftY=START_Y.
- Simultaneous events:
  - A restart edge and a startOfFrame on the same clk in SHOW: the restart wins if the counter is already saturated.
  - The PLAY entry condition is not re-evaluated until the first startOfFrame after returning to PLAY.
- topLeftX is constant TARGET_X in every state.
- Latency: outputs change 1 clk after the triggering edge or startOfFrame.

Decomposition:
- Package game_over_pkg holds:
  - the state enum (3-bit) and the screen constants SCREEN_W=640, SCREEN_H=480;
  - the bitmap size BITMAP_W=BITMAP_H=32;
  - the default TARGET_X/TARGET_Y derived from these.
- One sub-module, frame_tick_counter:
  - 8-bit counter, increments on startOfFrame, synchronous clear input;
  - outputs done when count==limit;
  - instantiated once and shared across FREEZE/BLINK/SHOW.

Test Plan:
- Reset mid-BLINK (pulse resetN low asynchronously) -> same-cycle outputs gameOver=0, freezeGame=0, topLeftY=0, stateOut=0.
- FREEZE_FRAMES=3, assert birdsExhausted=1, allSettled=1, pigsRemaining=2, then 3 startOfFrame pulses -> freezeGame=1 after the first sampling frame; SLIDE entered after the 3rd pulse with gameOver=1, topLeftY=0. Repeat with pigsRemaining=0 -> stays PLAY.
- SLIDE with START_Y=0, TARGET_Y=20, SLIDE_STEP=8 -> topLeftY sequence 8, 16, 20 (clamped), then BLINK.
- BLINK_FRAMES=2, BLINK_TOGGLES=4 -> gameOver pattern 1,1,0,0,1,1,0,0 (per frame), then SHOW with gameOver=1 steady.
- MIN_SHOW_FRAMES=5: restart edge at frame 2 -> ignored; key held high through frame 6 -> no restart; release then re-press at frame 7 -> single-clk restartPulse=1, PLAY next clk with freezeGame=0.
